id_stage: RTL and testbench



---
 rtl/id_stage_if.sv | 28 ++
 rtl/id_stage.sv | 198 +++++++++++++++++++
 tb/tb_id_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// ID -> EXE bundle: decoded operands and control presented to the execute stage.
interface id_stage_if;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [3:0]  dest;
  logic [3:0]  exe_cmd;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en;
  logic        b;
  logic        s;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  // Decode stage drives the bundle.
  modport master (
    output pc, val_rn, val_rm, dest, exe_cmd, mem_r_en, mem_w_en, wb_en,
           b, s, imm, shift_operand, signed_imm_24
  );

  // Execute stage consumes it.
  modport slave (
    input pc, val_rn, val_rm, dest, exe_cmd, mem_r_en, mem_w_en, wb_en,
          b, s, imm, shift_operand, signed_imm_24
  );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 16x32 register file with
// write-through, decoder, condition check and data-hazard detector.
// Optional macro FORWARDING_EN: when defined, only load-use dependencies
// against the EXE stage stall; otherwise any EXE/MEM producer match stalls.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic [3:0]  status,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic        exe_wb_en,
  input  logic [3:0]  exe_dest,
  input  logic        exe_mem_r_en,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  output logic        hazard,
  id_stage_if.master  id_out
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
    OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
    OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10
  } mode_e;

  logic        valid;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] regs [16];

  // IF/ID pipeline register: flush kills, hazard holds, otherwise load.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (flush) begin
      valid  <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (!hazard) begin
      valid  <= 1'b1;
      pc_q   <= if_pc;
      inst_q <= if_inst;
    end
  end

  // Register file write port; every entry clears on reset.
  // NOTE: a reset on the array forces it into flops; a RAM macro could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_dest] <= wb_value;
    end
  end

  // Instruction fields.
  logic [3:0] cond;
  logic [1:0] mode;
  opcode_e    opcode;
  logic       i_bit;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] rm;
  logic       is_str;
  logic [3:0] src2_idx;

  assign cond     = inst_q[31:28];
  assign mode     = inst_q[27:26];
  assign i_bit    = inst_q[25];
  assign opcode   = opcode_e'(inst_q[24:21]);
  assign s_bit    = inst_q[20];
  assign rn       = inst_q[19:16];
  assign rd       = inst_q[15:12];
  assign rm       = inst_q[3:0];
  assign is_str   = (mode == MODE_MEM) && !s_bit;
  assign src2_idx = is_str ? rd : rm;

  // Combinational reads with write-through so a same-cycle writeback is seen.
  logic [31:0] rd_rn;
  logic [31:0] rd_rm;
  assign rd_rn = (wb_en && wb_dest == rn)       ? wb_value : regs[rn];
  assign rd_rm = (wb_en && wb_dest == src2_idx) ? wb_value : regs[src2_idx];

  // Raw decode of control fields, before validity/condition/hazard gating.
  logic [3:0] dec_cmd;
  logic       dec_mr, dec_mw, dec_wb, dec_b, dec_s;
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec_cmd = 4'b0000;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wb  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    case (mode)
      MODE_ALU: begin
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (opcode)
          OP_MOV:  dec_cmd = 4'b0001;
          OP_MVN:  dec_cmd = 4'b1001;
          OP_ADD:  dec_cmd = 4'b0010;
          OP_ADC:  dec_cmd = 4'b0011;
          OP_SUB:  dec_cmd = 4'b0100;
          OP_SBC:  dec_cmd = 4'b0101;
          OP_AND:  dec_cmd = 4'b0110;
          OP_ORR:  dec_cmd = 4'b0111;
          OP_EOR:  dec_cmd = 4'b1000;
          OP_CMP:  begin dec_cmd = 4'b0100; dec_wb = 1'b0; dec_s = 1'b1; end
          OP_TST:  begin dec_cmd = 4'b0110; dec_wb = 1'b0; dec_s = 1'b1; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        dec_cmd = 4'b0010;
        if (s_bit) begin
          dec_mr = 1'b1;
          dec_wb = 1'b1;
        end else begin
          dec_mw = 1'b1;
        end
      end
      MODE_BR: dec_b = 1'b1;
      default: ;
    endcase
  end

  // Condition-code evaluation against {N,Z,C,V}.
  logic n_f, z_f, c_f, v_f, cond_ok;
  assign {n_f, z_f, c_f, v_f} = status;
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Hazard: a source actually read by this instruction matches a live producer.
  logic use_src1, use_src2, exe_hit, mem_hit;
  assign use_src1 = !((mode == MODE_ALU) && (opcode == OP_MOV || opcode == OP_MVN))
                    && (mode != MODE_BR);
  assign use_src2 = ((mode == MODE_ALU) && !i_bit) || is_str;
  assign exe_hit  = (use_src1 && exe_dest == rn) || (use_src2 && exe_dest == src2_idx);
  assign mem_hit  = (use_src1 && mem_dest == rn) || (use_src2 && mem_dest == src2_idx);

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign hazard = valid && exe_wb_en && exe_mem_r_en && exe_hit;
`else
  assign hazard = valid && ((exe_wb_en && exe_hit) || (mem_wb_en && mem_hit));
`endif

  // Control issues only for a valid, condition-passing, non-stalled instruction.
  logic issue;
  assign issue = valid && cond_ok && !hazard;

  assign id_out.exe_cmd       = issue ? dec_cmd : 4'b0000;
  assign id_out.mem_r_en      = issue && dec_mr;
  assign id_out.mem_w_en      = issue && dec_mw;
  assign id_out.wb_en         = issue && dec_wb;
  assign id_out.b             = issue && dec_b;
  assign id_out.s             = issue && dec_s;
  assign id_out.pc            = pc_q;
  assign id_out.val_rn        = rd_rn;
  assign id_out.val_rm        = rd_rm;
  assign id_out.dest          = rd;
  assign id_out.imm           = i_bit;
  assign id_out.shift_operand = inst_q[11:0];
  assign id_out.signed_imm_24 = inst_q[23:0];

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed steps, then randomized traffic
// compared against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] if_pc, if_inst;
  logic [3:0]  status;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en;
  logic [3:0]  exe_dest;
  logic        exe_mem_r_en;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        hazard;

  id_stage_if ex_if ();

  id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .if_pc(if_pc), .if_inst(if_inst),
    .status(status), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard), .id_out(ex_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; if_pc = 0; if_inst = 0; status = 0;
    wb_en = 0; wb_dest = 0; wb_value = 0;
    exe_wb_en = 0; exe_dest = 0; exe_mem_r_en = 0;
    mem_wb_en = 0; mem_dest = 0;
  endtask

  // Producer in EXE that stalls in either build (it is a load).
  task automatic set_exe_load(input logic [3:0] d);
    exe_wb_en = 1; exe_dest = d; exe_mem_r_en = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] cmd;
    logic mr, mw, wb, b, s;
  } ctl_t;

  logic [31:0] m_regs [16];
  logic        m_valid;
  logic [31:0] m_pc, m_inst;

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cy, v;
    {n, z, cy, v} = st;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {listed, alu command} for a data-processing opcode.
  function automatic logic [4:0] alu_lookup(input logic [3:0] op);
    case (op)
      4'b1101: return 5'h11;  4'b1111: return 5'h19;
      4'b0100: return 5'h12;  4'b0101: return 5'h13;
      4'b0010: return 5'h14;  4'b0110: return 5'h15;
      4'b0000: return 5'h16;  4'b1100: return 5'h17;
      4'b0001: return 5'h18;  4'b1010: return 5'h14;
      4'b1000: return 5'h16;
      default: return 5'h00;
    endcase
  endfunction

  function automatic ctl_t ref_ctl(input logic [31:0] inst, input logic [3:0] st);
    ctl_t c;
    logic [4:0] e;
    logic       cmp_like;
    c = '0;
    if (!cond_true(inst[31:28], st)) return c;
    case (inst[27:26])
      2'b00: begin
        e = alu_lookup(inst[24:21]);
        cmp_like = (inst[24:21] == 4'b1010) || (inst[24:21] == 4'b1000);
        if (e[4]) begin
          c.cmd = e[3:0];
          c.wb  = !cmp_like;
          c.s   = inst[20] || cmp_like;
        end
      end
      2'b01: begin
        c.cmd = 4'b0010;
        if (inst[20]) begin c.mr = 1; c.wb = 1; end
        else c.mw = 1;
      end
      2'b10: c.b = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] read_reg(input logic [3:0] idx);
    return (wb_en && wb_dest == idx) ? wb_value : m_regs[idx];
  endfunction

  function automatic logic [3:0] src2_of(input logic [31:0] inst);
    return (inst[27:26] == 2'b01 && !inst[20]) ? inst[15:12] : inst[3:0];
  endfunction

  function automatic logic ref_hazard(input logic v, input logic [31:0] inst);
    logic [3:0] srcs [$];
    logic hit;
    logic [1:0] mode;
    mode = inst[27:26];
    hit = 0;
    if (!v) return 1'b0;
    if (!(mode == 2'b10 || (mode == 2'b00 &&
          (inst[24:21] == 4'b1101 || inst[24:21] == 4'b1111))))
      srcs.push_back(inst[19:16]);
    if ((mode == 2'b00 && !inst[25]) || (mode == 2'b01 && !inst[20]))
      srcs.push_back(src2_of(inst));
    foreach (srcs[k]) begin
`ifdef FORWARDING_EN
      if (exe_wb_en && exe_mem_r_en && exe_dest == srcs[k]) hit = 1;
`else
      if (exe_wb_en && exe_dest == srcs[k]) hit = 1;
      if (mem_wb_en && mem_dest == srcs[k]) hit = 1;
`endif
    end
    return hit;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ctl_t       ec;
    logic       eh;
    logic [3:0] cnd;

    clear_inputs();
    rst = 1;
    #2;
    check("rst_hazard", hazard, 0);
    check("rst_cmd", ex_if.exe_cmd, 0);
    check("rst_wb", ex_if.wb_en, 0);
    check("rst_pc", ex_if.pc, 0);
    check("rst_dest", ex_if.dest, 0);
    check("rst_rn", ex_if.val_rn, 0);
    check("rst_simm", ex_if.signed_imm_24, 0);
    next_cycle();
    rst = 0;

    // MOV R0,#20
    if_inst = 32'hE3A00014; if_pc = 32'h4;
    next_cycle();
    #1;
    check("mov_cmd", ex_if.exe_cmd, 4'b0001);
    check("mov_wb", ex_if.wb_en, 1);
    check("mov_imm", ex_if.imm, 1);
    check("mov_dest", ex_if.dest, 0);
    check("mov_shop", ex_if.shift_operand, 12'h014);
    check("mov_hazard", hazard, 0);
    check("mov_pc", ex_if.pc, 32'h4);

    // ADDS R3,R2,R2 with same-cycle writeback of R2
    if_inst = 32'hE0923002; if_pc = 32'h8;
    next_cycle();
    wb_en = 1; wb_dest = 2; wb_value = 32'h300;
    #1;
    check("adds_rn", ex_if.val_rn, 32'h300);
    check("adds_rm", ex_if.val_rm, 32'h300);
    check("adds_cmd", ex_if.exe_cmd, 4'b0010);
    check("adds_s", ex_if.s, 1);

    // BLT: taken with N!=V, suppressed with N==V
    if_inst = 32'hBAFFFFF7; if_pc = 32'hC; status = 4'b1000;
    next_cycle();
    wb_en = 0;
    #1;
    check("blt_b_taken", ex_if.b, 1);
    check("blt_simm", ex_if.signed_imm_24, 24'hFFFFF7);
    check("blt_wb", ex_if.wb_en, 0);
    status = 4'b0000;
    #1;
    check("blt_b_not", ex_if.b, 0);

    // ADD R3,R2,R2 (no S): R2 now comes from the array
    if_inst = 32'hE0823002; if_pc = 32'h10;
    next_cycle();
    #1;
    check("add_rn_stored", ex_if.val_rn, 32'h300);
    check("add_s", ex_if.s, 0);

    // Dependency on R2 in EXE
    if_inst = 32'hE0923002; if_pc = 32'h14;
    next_cycle();
    if_inst = 32'hE3A00014; if_pc = 32'h18;
`ifdef FORWARDING_EN
    exe_wb_en = 1; exe_dest = 2; exe_mem_r_en = 0;
    #1;
    check("fwd_alu_nohaz", hazard, 0);
    check("fwd_alu_cmd", ex_if.exe_cmd, 4'b0010);
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 2;
    #1;
    check("fwd_mem_nohaz", hazard, 0);
    mem_wb_en = 0;
`else
    exe_wb_en = 1; exe_dest = 2; exe_mem_r_en = 0;
    #1;
    check("exe_alu_haz", hazard, 1);
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 2;
    #1;
    check("mem_haz", hazard, 1);
    mem_wb_en = 0;
`endif
    set_exe_load(2);
    #1;
    check("load_haz", hazard, 1);
    check("haz_cmd0", ex_if.exe_cmd, 0);
    check("haz_wb0", ex_if.wb_en, 0);
    check("haz_s0", ex_if.s, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check("hold_haz", hazard, 1);
      check("hold_shop", ex_if.shift_operand, 12'h002);
      check("hold_pc", ex_if.pc, 32'h14);
    end
    exe_dest = 5;
    #1;
    check("release_haz", hazard, 0);
    check("release_cmd", ex_if.exe_cmd, 4'b0010);
    next_cycle();
    exe_wb_en = 0; exe_mem_r_en = 0;
    #1;
    check("after_hold_shop", ex_if.shift_operand, 12'h014);
    check("after_hold_cmd", ex_if.exe_cmd, 4'b0001);

    // flush together with hazard
    if_inst = 32'hE0923002; if_pc = 32'h1C;
    next_cycle();
    set_exe_load(2);
    #1;
    check("pre_flush_haz", hazard, 1);
    flush = 1;
    next_cycle();
    flush = 0;
    #1;
    check("flush_haz", hazard, 0);
    check("flush_cmd", ex_if.exe_cmd, 0);
    check("flush_wb", ex_if.wb_en, 0);
    check("flush_shop", ex_if.shift_operand, 0);

    // reset in the middle of a stall drops hazard without a clock edge
    next_cycle();
    #1;
    check("pre_rst_haz", hazard, 1);
    #1;
    rst = 1;
    #1;
    check("async_rst_haz", hazard, 0);
    check("async_rst_rn", ex_if.val_rn, 0);
    check("async_rst_cmd", ex_if.exe_cmd, 0);
    clear_inputs();
    next_cycle();
    rst = 0;

    // Randomized traffic against the model (model starts from reset).
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_valid = 0; m_pc = 0; m_inst = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      cnd = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
      if_inst = {cnd, 2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 8'($urandom), 4'($urandom_range(0, 3))};
      if_pc        = $urandom;
      status       = 4'($urandom);
      flush        = ($urandom_range(0, 9) == 0);
      wb_en        = ($urandom_range(0, 1) == 1);
      wb_dest      = 4'($urandom_range(0, 3));
      wb_value     = $urandom;
      exe_wb_en    = ($urandom_range(0, 2) == 0);
      exe_dest     = 4'($urandom_range(0, 3));
      exe_mem_r_en = ($urandom_range(0, 1) == 1);
      mem_wb_en    = ($urandom_range(0, 2) == 0);
      mem_dest     = 4'($urandom_range(0, 3));
      #2;
      eh = ref_hazard(m_valid, m_inst);
      ec = (m_valid && !eh) ? ref_ctl(m_inst, status) : '0;
      check("rnd_haz", hazard, eh);
      check("rnd_cmd", ex_if.exe_cmd, ec.cmd);
      check("rnd_mr", ex_if.mem_r_en, ec.mr);
      check("rnd_mw", ex_if.mem_w_en, ec.mw);
      check("rnd_wb", ex_if.wb_en, ec.wb);
      check("rnd_b", ex_if.b, ec.b);
      check("rnd_s", ex_if.s, ec.s);
      check("rnd_rn", ex_if.val_rn, read_reg(m_inst[19:16]));
      check("rnd_rm", ex_if.val_rm, read_reg(src2_of(m_inst)));
      check("rnd_dest", ex_if.dest, m_inst[15:12]);
      check("rnd_imm", ex_if.imm, m_inst[25]);
      check("rnd_shop", ex_if.shift_operand, m_inst[11:0]);
      check("rnd_simm", ex_if.signed_imm_24, m_inst[23:0]);
      if (m_valid) check("rnd_pc", ex_if.pc, m_pc);
      // state advance at the coming edge
      if (wb_en) m_regs[wb_dest] = wb_value;
      if (flush) begin
        m_valid = 0; m_inst = 0; m_pc = 0;
      end else if (!eh) begin
        m_valid = 1; m_inst = if_inst; m_pc = if_pc;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
